char_column_segment: RTL and testbench
======================================

# char_column_segment

Downstream of the plate border adjustment stage. Takes the binarised pixel stream plus the adjusted plate borders and existence flag. Builds a per-column foreground-hit map inside the plate window during each frame. After frame end, scans the map to produce up to MAX_CHAR character column intervals for the character recognition stage.

## Interface
- IMG_W, 640, active pixels per line (≤1024)
- IMG_H, 480, active lines per frame (≤1024)
- MAX_CHAR, 8, maximum stored character intervals
- MIN_CHAR_W, 2, minimum run width in columns to count as a character
- clk  in  1  pixel clock; one clock domain
- rst_n  in  1  reset, synchronous, active-high (asserted = 1); port name kept for codebase consistency
- per_frame_vsync  in  1  frame sync, high during active frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel valid strobe
- per_img_bit  in  1  binarised pixel, 1 = foreground
- plate_boarder_up/down/left/right  in  10 each  adjusted plate window, inclusive
- plate_exist_flag  in  1  plate present for this frame
- char_num  out  4  number of stored intervals, 0..MAX_CHAR
- char_left  out  10*MAX_CHAR  packed left columns; entry k at [10k+9:10k]
- char_right  out  10*MAX_CHAR  packed right columns, same packing
- char_valid  out  1  one-cycle pulse when a new result is loaded
- seg_busy  out  1  high in CLEAR or SCAN
- seg_overrun  out  1  one-cycle pulse when a frame starts during SCAN

## Operation
- Coordinates: x counts clken pulses while href is high and returns to 0 on href falling. y increments on href falling. Both return to 0 on vsync rising.
- Window latch: the upstream borders update one cycle after vsync rising. The block registers up/down/left/right/exist on the cycle after it detects vsync rising.
- Collect, when exist = 1 and state = IDLE:
  - a pixel with bit = 1, up ≤ y ≤ down and left ≤ x ≤ right writes 1 to hit[x];
  - writes are set-only.
- FSM states: CLEAR, IDLE, SCAN, DONE.
  - CLEAR: entered on reset; writes 0 to addresses 0..IMG_W-1, one per cycle, then goes to IDLE.
  - IDLE → SCAN on vsync falling when the latched exist = 1.
  - IDLE → DONE directly when latched exist = 0; the result has char_num = 0.
  - SCAN: reads addresses left..right, one per cycle, and writes 0 to each address read (read-and-clear).
  - DONE lasts one cycle, then goes to IDLE.
- Run extraction, in column order:
  - 0→1 transition: opens a run, start = column.
  - 1→0 transition at column c: closes the run with end = c-1.
  - A run still open at column right closes with end = right.
  - A closed run is stored only if end-start+1 ≥ MIN_CHAR_W and fewer than MAX_CHAR runs are already stored.
  - Runs beyond MAX_CHAR are dropped silently.
- Results: in DONE, char_num/char_left/char_right load from the working registers and char_valid pulses. Outputs hold until the next DONE. Unused entries read 0.
- Overrun: if vsync rises while in SCAN, that frame collects nothing, seg_overrun pulses, and the scan completes normally. The result for the skipped frame reports char_num = 0.
- Degenerate window (latched right < left or down < up): handled as exist = 0.
- Reset in any state: aborts, clears all outputs and working registers, and enters CLEAR.

## Timing
- Reset values: char_num 0, char_left 0, char_right 0, char_valid 0, seg_busy 1 (CLEAR), seg_overrun 0.
- CLEAR lasts IMG_W cycles.
- Hit RAM: synchronous read with 1-cycle latency. A write in the same cycle as a read returns the old data.
- Let F be the cycle in which vsync falling is detected. SCAN issues address left at F+1 and address right at F+1+(right-left). The last data arrives the cycle after that. DONE and char_valid occur at F+(right-left)+3.
- With exist = 0, char_valid occurs at F+1.
- Vertical blanking must exceed IMG_W+3 cycles to avoid overrun.

## Structure
- Shared include plate_defines.vh holds:
  - IMG_W, IMG_H and the coordinate width (10);
  - the FSM state encodings (CLEAR=0, IDLE=1, SCAN=2, DONE=3).
- Sub-module col_hit_ram: IMG_W×1 single-port RAM with synchronous read and write enable. Collect, CLEAR and SCAN never overlap, so one port suffices.

## Test plan
- Reset → all outputs 0 and seg_busy high for 640 cycles, then seg_busy low.
- Window up=100/down=130/left=200/right=300, exist=1, foreground in columns 210–219, 230–241 and 260–260 (1 column wide) → char_num=2, char_left={230,210}, char_right={241,219}, char_valid at F+103.
- Foreground at column 300 with the run open to the edge, plus column 150 outside the window → single interval 295–300 when column 295 starts the run; column 150 is ignored and cleared, and the next empty frame gives char_num=0.
- Ten 4-column runs in the window → char_num=8; entries hold the first eight runs.
- exist=0 with foreground present → char_valid at F+1, char_num=0.
- Second vsync rise in SCAN → seg_overrun pulses; the next result is char_num=0. Reset asserted mid-SCAN → outputs 0, CLEAR restarted.

Source files
------------

// File: rtl/char_column_segment_pkg.sv
`default_nettype none
// =============================================================================
// Module      : char_column_segment_pkg
// Description : Shared geometry defaults, coordinate type and FSM encoding.
// Revision    : 1.0 - initial release
// =============================================================================
package char_column_segment_pkg;

    localparam int DEF_IMG_W      = 640;
    localparam int DEF_IMG_H      = 480;
    localparam int DEF_MAX_CHAR   = 8;
    localparam int DEF_MIN_CHAR_W = 2;
    localparam int COORD_W        = 10;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } seg_state_e;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/char_column_segment_col_hit_ram.sv
`default_nettype none
// =============================================================================
// Module      : char_column_segment_col_hit_ram
// Description : One-bit-wide column hit map, single port, read-before-write.
// Revision    : 1.0 - initial release
// =============================================================================
module char_column_segment_col_hit_ram #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic          i_wdata,
    output logic          o_rdata
);

    logic mem_q [DEPTH];
    logic rd_data_q;
    logic w_addr_ok;

    // Addresses past the map (wide plate windows) read as empty and ignore writes.
    assign w_addr_ok = int'(i_addr) < DEPTH;

    always_ff @(posedge clk) begin
        if (i_we && w_addr_ok) begin
            mem_q[i_addr] <= i_wdata;
        end
        rd_data_q <= w_addr_ok ? mem_q[i_addr] : 1'b0;
    end

    assign o_rdata = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/char_column_segment.sv
`default_nettype none
// =============================================================================
// Module      : char_column_segment
// Description : Builds a per-column foreground map inside the plate window and
//               extracts character column intervals after each frame.
// Revision    : 1.0 - initial release
// =============================================================================
module char_column_segment
    import char_column_segment_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int MAX_CHAR   = DEF_MAX_CHAR,
    parameter int MIN_CHAR_W = DEF_MIN_CHAR_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        per_frame_vsync,
    input  logic                        per_frame_href,
    input  logic                        per_frame_clken,
    input  logic                        per_img_bit,
    input  logic [COORD_W-1:0]          plate_boarder_up,
    input  logic [COORD_W-1:0]          plate_boarder_down,
    input  logic [COORD_W-1:0]          plate_boarder_left,
    input  logic [COORD_W-1:0]          plate_boarder_right,
    input  logic                        plate_exist_flag,
    output logic [3:0]                  char_num,
    output logic [COORD_W*MAX_CHAR-1:0] char_left,
    output logic [COORD_W*MAX_CHAR-1:0] char_right,
    output logic                        char_valid,
    output logic                        seg_busy,
    output logic                        seg_overrun
);

    logic       vsync_q, vsync_d;
    logic       href_q, href_d;
    logic       latch_pend_q, latch_pend_d;
    coord_t     x_q, x_d, y_q, y_d;
    coord_t     win_up_q, win_up_d, win_down_q, win_down_d;
    coord_t     win_left_q, win_left_d, win_right_q, win_right_d;
    logic       win_exist_q, win_exist_d;
    logic       skip_q, skip_d;
    logic       overrun_q, overrun_d;

    seg_state_e state_q, state_d;
    coord_t     addr_q, addr_d;
    coord_t     scan_right_q, scan_right_d;
    logic       issue_done_q, issue_done_d;
    logic       rd_valid_q, rd_valid_d;
    coord_t     rd_col_q, rd_col_d;
    logic       run_open_q, run_open_d;
    coord_t     run_start_q, run_start_d;

    logic [3:0] work_num_q, work_num_d;
    coord_t     work_left_q [MAX_CHAR];
    coord_t     work_left_d [MAX_CHAR];
    coord_t     work_right_q [MAX_CHAR];
    coord_t     work_right_d [MAX_CHAR];
    logic [3:0] out_num_q, out_num_d;
    coord_t     out_left_q [MAX_CHAR];
    coord_t     out_left_d [MAX_CHAR];
    coord_t     out_right_q [MAX_CHAR];
    coord_t     out_right_d [MAX_CHAR];

    logic       w_vsync_rise, w_vsync_fall;
    logic       w_pix_hit;
    logic       w_ram_we, w_ram_wdata, w_ram_rdata;
    coord_t     w_ram_addr;
    logic       w_run_close;
    coord_t     w_close_start, w_close_end;
    int         w_close_w;

    assign w_vsync_rise = per_frame_vsync && !vsync_q;
    assign w_vsync_fall = !per_frame_vsync && vsync_q;

    // Pixels are ignored on the frame-start cycle and while the new window is being latched.
    assign w_pix_hit = (state_q == ST_IDLE) && win_exist_q && !skip_q
                    && vsync_q && per_frame_vsync && !latch_pend_q
                    && per_frame_href && per_frame_clken && per_img_bit
                    && in_range(y_q, win_up_q, win_down_q)
                    && in_range(x_q, win_left_q, win_right_q)
                    && (int'(x_q) < IMG_W) && (int'(y_q) < IMG_H);

    always_comb begin
        vsync_d      = per_frame_vsync;
        href_d       = per_frame_href;
        latch_pend_d = w_vsync_rise;
        x_d          = x_q;
        y_d          = y_q;
        win_up_d     = win_up_q;
        win_down_d   = win_down_q;
        win_left_d   = win_left_q;
        win_right_d  = win_right_q;
        win_exist_d  = win_exist_q;
        skip_d       = skip_q;
        overrun_d    = w_vsync_rise && (state_q == ST_SCAN);

        if (w_vsync_rise) begin
            x_d    = '0;
            y_d    = '0;
            skip_d = (state_q == ST_SCAN);
        end else if (href_q && !per_frame_href) begin
            x_d = '0;
            y_d = y_q + 1'b1;
        end else if (per_frame_href && per_frame_clken) begin
            x_d = x_q + 1'b1;
        end

        if (latch_pend_q) begin
            win_up_d    = plate_boarder_up;
            win_down_d  = plate_boarder_down;
            win_left_d  = plate_boarder_left;
            win_right_d = plate_boarder_right;
            win_exist_d = plate_exist_flag
                       && (plate_boarder_right >= plate_boarder_left)
                       && (plate_boarder_down >= plate_boarder_up);
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        scan_right_d  = scan_right_q;
        issue_done_d  = issue_done_q;
        rd_valid_d    = 1'b0;
        rd_col_d      = rd_col_q;
        run_open_d    = run_open_q;
        run_start_d   = run_start_q;
        work_num_d    = work_num_q;
        work_left_d   = work_left_q;
        work_right_d  = work_right_q;
        out_num_d     = out_num_q;
        out_left_d    = out_left_q;
        out_right_d   = out_right_q;
        w_ram_we      = 1'b0;
        w_ram_wdata   = 1'b0;
        w_ram_addr    = x_q;
        w_run_close   = 1'b0;
        w_close_start = run_start_q;
        w_close_end   = rd_col_q;
        w_close_w     = 0;

        case (state_q)
            ST_CLEAR: begin
                w_ram_we   = 1'b1;
                w_ram_addr = addr_q;
                if (addr_q == coord_t'(IMG_W - 1)) begin
                    state_d = ST_IDLE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            ST_IDLE: begin
                w_ram_we    = w_pix_hit;
                w_ram_wdata = 1'b1;
                w_ram_addr  = x_q;
                if (w_vsync_fall) begin
                    work_num_d   = '0;
                    work_left_d  = '{default: '0};
                    work_right_d = '{default: '0};
                    if (win_exist_q && !skip_q) begin
                        state_d      = ST_SCAN;
                        addr_d       = win_left_q;
                        scan_right_d = win_right_q;
                        issue_done_d = 1'b0;
                        run_open_d   = 1'b0;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_SCAN: begin
                // Read-and-clear leaves the map empty for the next frame.
                if (!issue_done_q) begin
                    w_ram_we   = 1'b1;
                    w_ram_addr = addr_q;
                    rd_valid_d = 1'b1;
                    rd_col_d   = addr_q;
                    if (addr_q == scan_right_q) begin
                        issue_done_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
                if (rd_valid_q && (rd_col_q == scan_right_q)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase

        if ((state_q == ST_SCAN) && rd_valid_q) begin
            if (w_ram_rdata) begin
                if (!run_open_q) begin
                    run_open_d  = 1'b1;
                    run_start_d = rd_col_q;
                end
                if (rd_col_q == scan_right_q) begin
                    w_run_close   = 1'b1;
                    w_close_start = run_open_q ? run_start_q : rd_col_q;
                    w_close_end   = rd_col_q;
                    run_open_d    = 1'b0;
                end
            end else if (run_open_q) begin
                w_run_close   = 1'b1;
                w_close_start = run_start_q;
                w_close_end   = rd_col_q - 1'b1;
                run_open_d    = 1'b0;
            end
        end

        w_close_w = int'(w_close_end) - int'(w_close_start) + 1;
        if (w_run_close && (w_close_w >= MIN_CHAR_W) && (int'(work_num_q) < MAX_CHAR)) begin
            for (int k = 0; k < MAX_CHAR; k++) begin
                if (int'(work_num_q) == k) begin
                    work_left_d[k]  = w_close_start;
                    work_right_d[k] = w_close_end;
                end
            end
            work_num_d = work_num_q + 1'b1;
        end

        // Loading on entry makes the results visible in the same cycle as char_valid.
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            out_num_d   = work_num_d;
            out_left_d  = work_left_d;
            out_right_d = work_right_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            latch_pend_q <= 1'b0;
            x_q          <= '0;
            y_q          <= '0;
            win_up_q     <= '0;
            win_down_q   <= '0;
            win_left_q   <= '0;
            win_right_q  <= '0;
            win_exist_q  <= 1'b0;
            skip_q       <= 1'b0;
            overrun_q    <= 1'b0;
            state_q      <= ST_CLEAR;
            addr_q       <= '0;
            scan_right_q <= '0;
            issue_done_q <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_col_q     <= '0;
            run_open_q   <= 1'b0;
            run_start_q  <= '0;
            work_num_q   <= '0;
            work_left_q  <= '{default: '0};
            work_right_q <= '{default: '0};
            out_num_q    <= '0;
            out_left_q   <= '{default: '0};
            out_right_q  <= '{default: '0};
        end else begin
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            latch_pend_q <= latch_pend_d;
            x_q          <= x_d;
            y_q          <= y_d;
            win_up_q     <= win_up_d;
            win_down_q   <= win_down_d;
            win_left_q   <= win_left_d;
            win_right_q  <= win_right_d;
            win_exist_q  <= win_exist_d;
            skip_q       <= skip_d;
            overrun_q    <= overrun_d;
            state_q      <= state_d;
            addr_q       <= addr_d;
            scan_right_q <= scan_right_d;
            issue_done_q <= issue_done_d;
            rd_valid_q   <= rd_valid_d;
            rd_col_q     <= rd_col_d;
            run_open_q   <= run_open_d;
            run_start_q  <= run_start_d;
            work_num_q   <= work_num_d;
            work_left_q  <= work_left_d;
            work_right_q <= work_right_d;
            out_num_q    <= out_num_d;
            out_left_q   <= out_left_d;
            out_right_q  <= out_right_d;
        end
    end

    char_column_segment_col_hit_ram #(
        .DEPTH (IMG_W),
        .AW    (COORD_W)
    ) u_col_hit_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    for (genvar k = 0; k < MAX_CHAR; k++) begin : g_pack
        assign char_left[COORD_W*k +: COORD_W]  = out_left_q[k];
        assign char_right[COORD_W*k +: COORD_W] = out_right_q[k];
    end

    assign char_num    = out_num_q;
    assign char_valid  = (state_q == ST_DONE);
    assign seg_busy    = (state_q == ST_CLEAR) || (state_q == ST_SCAN);
    assign seg_overrun = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_char_column_segment.sv
`default_nettype none
// =============================================================================
// Module      : tb_char_column_segment
// Description : Directed and randomized frames against a column-run reference.
// Revision    : 1.0 - initial release
// =============================================================================
module tb_char_column_segment;

    localparam int IMG_W      = 640;
    localparam int MAX_CHAR   = 8;
    localparam int MIN_CHAR_W = 2;
    localparam int CW         = 10;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   vsync = 1'b0;
    logic                   href = 1'b0;
    logic                   clken = 1'b0;
    logic                   pix = 1'b0;
    logic [CW-1:0]          b_up = '0, b_dn = '0, b_lf = '0, b_rt = '0;
    logic                   b_ex = 1'b0;
    logic [3:0]             char_num;
    logic [CW*MAX_CHAR-1:0] char_left, char_right;
    logic                   char_valid, seg_busy, seg_overrun;

    int errors = 0;
    int checks = 0;
    bit pat [IMG_W];
    int exp_num;
    int exp_l [MAX_CHAR];
    int exp_r [MAX_CHAR];
    int lat;

    char_column_segment dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .per_frame_vsync     (vsync),
        .per_frame_href      (href),
        .per_frame_clken     (clken),
        .per_img_bit         (pix),
        .plate_boarder_up    (b_up),
        .plate_boarder_down  (b_dn),
        .plate_boarder_left  (b_lf),
        .plate_boarder_right (b_rt),
        .plate_exist_flag    (b_ex),
        .char_num            (char_num),
        .char_left           (char_left),
        .char_right          (char_right),
        .char_valid          (char_valid),
        .seg_busy            (seg_busy),
        .seg_overrun         (seg_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_pat();
        for (int i = 0; i < IMG_W; i++) pat[i] = 1'b0;
    endtask

    task automatic set_run(input int s, input int e);
        for (int i = s; i <= e; i++) pat[i] = 1'b1;
    endtask

    task automatic random_pat(input int lf, input int rt);
        int c, stop, n;
        bit v;
        clear_pat();
        c    = (lf > 3) ? lf - 3 : 0;
        stop = (rt + 3 < IMG_W) ? rt + 3 : IMG_W - 1;
        v    = bit'($urandom_range(0, 1));
        while (c <= stop) begin
            n = $urandom_range(1, 6);
            for (int j = 0; j < n && c < IMG_W; j++) begin
                pat[c] = v;
                c++;
            end
            v = !v;
        end
    endtask

    // Reference: the set of hit columns, then maximal runs of ones left to right.
    task automatic model(input int up, input int dn, input int lf, input int rt, input bit ex,
                         input int row_lo, input int row_hi, input int len);
        bit col [IMG_W];
        int c, s;
        exp_num = 0;
        for (int k = 0; k < MAX_CHAR; k++) begin
            exp_l[k] = 0;
            exp_r[k] = 0;
        end
        lat = 1;
        if (!ex || rt < lf || dn < up) return;
        lat = rt - lf + 3;
        for (int i = 0; i < IMG_W; i++)
            col[i] = (i >= lf && i <= rt && i < len && row_lo <= dn && row_hi >= up) ? pat[i] : 1'b0;
        c = lf;
        while (c <= rt) begin
            if (c < IMG_W && col[c]) begin
                s = c;
                while (c <= rt && c < IMG_W && col[c]) c++;
                if (c - s >= MIN_CHAR_W && exp_num < MAX_CHAR) begin
                    exp_l[exp_num] = s;
                    exp_r[exp_num] = c - 1;
                    exp_num++;
                end
            end else begin
                c++;
            end
        end
    endtask

    task automatic expect_empty();
        exp_num = 0;
        for (int k = 0; k < MAX_CHAR; k++) begin
            exp_l[k] = 0;
            exp_r[k] = 0;
        end
    endtask

    task automatic start_frame(input int up, input int dn, input int lf, input int rt, input bit ex);
        vsync = 1'b1;
        tick();
        b_up = CW'(up);
        b_dn = CW'(dn);
        b_lf = CW'(lf);
        b_rt = CW'(rt);
        b_ex = ex;
        tick();
        tick();
    endtask

    task automatic send_lines(input int row_lo, input int row_hi, input int len, input int nlines);
        int n;
        bit painted;
        for (int y = 0; y < nlines; y++) begin
            painted = (y >= row_lo && y <= row_hi);
            n = painted ? len : 1;
            href = 1'b1;
            for (int x = 0; x < n; x++) begin
                if ($urandom_range(0, 7) == 0) begin
                    clken = 1'b0;
                    pix   = 1'b0;
                    tick();
                end
                clken = 1'b1;
                pix   = painted ? pat[x] : 1'b0;
                tick();
            end
            clken = 1'b0;
            pix   = 1'b0;
            href  = 1'b0;
            tick();
            tick();
        end
    endtask

    task automatic check_result(input string tag);
        logic [CW*MAX_CHAR-1:0] el, er;
        el = '0;
        er = '0;
        for (int k = 0; k < MAX_CHAR; k++) begin
            el[CW*k +: CW] = CW'(exp_l[k]);
            er[CW*k +: CW] = CW'(exp_r[k]);
        end
        chk({tag, ".num"}, char_num, exp_num);
        chk({tag, ".left"}, char_left, el);
        chk({tag, ".right"}, char_right, er);
    endtask

    task automatic end_frame(input string tag, input int exp_lat);
        int k;
        vsync = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (char_valid !== 1'b1 && k < 3000);
        chk({tag, ".lat"}, k, exp_lat);
        check_result(tag);
        tick();
        chk({tag, ".pulse"}, char_valid, 1'b0);
        repeat (8) tick();
    endtask

    task automatic run_frame(input string tag, input int up, input int dn, input int lf, input int rt,
                             input bit ex, input int row_lo, input int row_hi, input int len);
        start_frame(up, dn, lf, rt, ex);
        send_lines(row_lo, row_hi, len, row_hi + 1);
        model(up, dn, lf, rt, ex, row_lo, row_hi, len);
        end_frame(tag, lat);
    endtask

    task automatic check_clear(input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (seg_busy === 1'b1 && k < 2000);
        chk({tag, ".clear_len"}, k, 640);
    endtask

    initial begin
        int up, dn, lf, rt, rlo, rhi, len, k;
        bit ex, seen;

        // Reset state
        repeat (3) tick();
        chk("rst.num", char_num, 4'd0);
        chk("rst.left", char_left, '0);
        chk("rst.right", char_right, '0);
        chk("rst.valid", char_valid, 1'b0);
        chk("rst.busy", seg_busy, 1'b1);
        chk("rst.overrun", seg_overrun, 1'b0);
        rst_n = 1'b0;
        check_clear("rst");
        repeat (5) tick();

        // Three runs, one of them too narrow
        clear_pat();
        set_run(210, 219);
        set_run(230, 241);
        set_run(260, 260);
        run_frame("three", 100, 130, 200, 300, 1'b1, 105, 105, 302);
        chk("three.num_const", char_num, 4'd2);

        // Run open to the right edge, plus a column outside the window
        clear_pat();
        set_run(295, 300);
        set_run(150, 150);
        run_frame("edge", 100, 130, 200, 300, 1'b1, 110, 111, 302);
        clear_pat();
        run_frame("empty", 100, 130, 200, 300, 1'b1, 110, 111, 302);

        // Ten runs, only eight stored
        clear_pat();
        for (int i = 0; i < 10; i++) set_run(202 + 8 * i, 205 + 8 * i);
        run_frame("ten", 100, 130, 200, 300, 1'b1, 100, 100, 302);

        // No plate and degenerate windows
        run_frame("noexist", 100, 130, 200, 300, 1'b0, 100, 100, 302);
        run_frame("degen_x", 0, 10, 300, 200, 1'b1, 3, 3, 302);
        run_frame("degen_y", 10, 5, 200, 300, 1'b1, 3, 3, 302);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            up  = $urandom_range(0, 30);
            dn  = up + $urandom_range(0, 10);
            lf  = $urandom_range(0, 500);
            rt  = lf + $urandom_range(0, 120);
            ex  = ($urandom_range(0, 5) != 0);
            rlo = $urandom_range(0, dn + 3);
            rhi = rlo + $urandom_range(0, 2);
            len = rt + 1 + $urandom_range(0, 3);
            if (f == 3) len = rt - 2;
            if (len > IMG_W) len = IMG_W;
            if (len < 1) len = 1;
            random_pat(lf, rt);
            run_frame($sformatf("rnd%0d", f), up, dn, lf, rt, ex, rlo, rhi, len);
        end

        // Overrun: a new frame starts while the previous one is still scanning
        random_pat(0, 500);
        start_frame(0, 5, 0, 500, 1'b1);
        send_lines(2, 2, 501, 3);
        model(0, 5, 0, 500, 1'b1, 2, 2, 501);
        vsync = 1'b0;
        k = 0;
        repeat (50) begin
            tick();
            k++;
        end
        vsync = 1'b1;
        seen = 1'b0;
        tick();
        k++;
        if (seg_overrun === 1'b1) seen = 1'b1;
        b_up = CW'(0);
        b_dn = CW'(5);
        b_lf = CW'(100);
        b_rt = CW'(200);
        b_ex = 1'b1;
        tick();
        k++;
        if (seg_overrun === 1'b1) seen = 1'b1;
        chk("ovr.pulse", seen, 1'b1);
        while (char_valid !== 1'b1 && k < 3000) begin
            tick();
            k++;
        end
        chk("ovr.scan_lat", k, 503);
        check_result("ovr.scan");
        repeat (3) tick();
        random_pat(100, 200);
        send_lines(1, 2, 201, 3);
        expect_empty();
        end_frame("ovr.skip", 1);
        clear_pat();
        run_frame("ovr.after", 0, 5, 100, 200, 1'b1, 1, 2, 201);

        // Reset during a scan, after a nonzero result is on the outputs
        clear_pat();
        set_run(210, 219);
        set_run(230, 241);
        run_frame("pre_rst", 100, 130, 200, 300, 1'b1, 105, 105, 302);
        random_pat(0, 400);
        set_run(30, 60);
        start_frame(0, 3, 0, 400, 1'b1);
        send_lines(1, 1, 401, 2);
        vsync = 1'b0;
        repeat (20) tick();
        rst_n = 1'b1;
        tick();
        tick();
        chk("mrst.num", char_num, 4'd0);
        chk("mrst.left", char_left, '0);
        chk("mrst.right", char_right, '0);
        chk("mrst.valid", char_valid, 1'b0);
        chk("mrst.busy", seg_busy, 1'b1);
        rst_n = 1'b0;
        check_clear("mrst");
        repeat (5) tick();
        clear_pat();
        run_frame("post_rst", 0, 3, 0, 400, 1'b1, 1, 1, 401);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
